ex_alu_unit: RTL and testbench

//  Execute-stage arithmetic core of the 5-stage MIPS pipeline.
//  - ALU control: decodes aluOp plus funct into a 4-bit operation.
//  - 32-bit ALU: computes result and zero flag.
//  - 10-bit branch adder: inPC + immediate.

---
 rtl/ex_alu_unit.sv | 83 ++++++++
 tb/tb_ex_alu_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/ex_alu_unit.sv
// Execute-stage arithmetic core: ALU control decode, 32-bit ALU and 10-bit branch adder.
// The result, zero flag and branch target are registered on the falling clock edge.
module ex_alu_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inData1,
  input  logic [31:0] inData2,
  input  logic [31:0] signExtend,
  input  logic [9:0]  inPC,
  input  logic [1:0]  aluOp,
  input  logic        aluSrc,
  output logic [31:0] aluResult,
  output logic        zero,
  output logic [9:0]  outPC,
  output logic [3:0]  operation
);

  logic [31:0] operand_b;
  logic [31:0] alu_comb;
  logic [9:0]  pc_comb;
  logic [5:0]  funct;

  // Declaration initialisers give a defined zero flag before the first edge in simulation.
  logic [31:0] result_q = 32'd0;
  logic        zero_q   = 1'b0;
  logic [9:0]  pc_q     = 10'd0;

  assign funct     = signExtend[5:0];
  assign operand_b = aluSrc ? signExtend : inData2;
  assign pc_comb   = inPC + signExtend[9:0];

  always_comb begin
    operation = 4'b0010;
    case (aluOp)
      2'b00: operation = 4'b0010;
      2'b01: operation = 4'b0110;
      2'b10: begin
        case (funct)
          6'b100000: operation = 4'b0010;
          6'b100010: operation = 4'b0110;
          6'b100100: operation = 4'b0000;
          6'b100101: operation = 4'b0001;
          6'b100110: operation = 4'b0011;
          6'b100111: operation = 4'b1100;
          6'b101010: operation = 4'b0111;
          default:   operation = 4'b0010;
        endcase
      end
      default: operation = 4'b0010;
    endcase
  end

  always_comb begin
    alu_comb = 32'd0;
    case (operation)
      4'b0000: alu_comb = inData1 & operand_b;
      4'b0001: alu_comb = inData1 | operand_b;
      4'b0011: alu_comb = inData1 ^ operand_b;
      4'b1100: alu_comb = ~(inData1 | operand_b);
      4'b0010: alu_comb = inData1 + operand_b;
      4'b0110: alu_comb = inData1 - operand_b;
      4'b0111: alu_comb = ($signed(inData1) < $signed(operand_b)) ? 32'd1 : 32'd0;
      default: alu_comb = 32'd0;
    endcase
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      result_q <= 32'd0;
      zero_q   <= 1'b0;
      pc_q     <= 10'd0;
    end else begin
      result_q <= alu_comb;
      zero_q   <= (alu_comb == 32'd0);
      pc_q     <= pc_comb;
    end
  end

  assign aluResult = result_q;
  assign zero      = zero_q;
  assign outPC     = pc_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Self-checking bench for ex_alu_unit: expected results are queued when stimulus is
// driven and compared after the falling edge that registers them.
module tb_ex_alu_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] inData1, inData2, signExtend;
  logic [9:0]  inPC;
  logic [1:0]  aluOp;
  logic        aluSrc;
  logic [31:0] aluResult;
  logic        zero;
  logic [9:0]  outPC;
  logic [3:0]  operation;

  typedef struct {
    logic [31:0] res;
    logic        zf;
    logic [9:0]  pc;
    logic [3:0]  op;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  ex_alu_unit dut (
    .clock(clock), .reset(reset), .inData1(inData1), .inData2(inData2),
    .signExtend(signExtend), .inPC(inPC), .aluOp(aluOp), .aluSrc(aluSrc),
    .aluResult(aluResult), .zero(zero), .outPC(outPC), .operation(operation)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [3:0] model_op(input logic [1:0] aop, input logic [5:0] f);
    if (aop == 2'b01) return 4'b0110;
    if (aop != 2'b10) return 4'b0010;
    if (f == 6'b100010) return 4'b0110;
    if (f == 6'b100100) return 4'b0000;
    if (f == 6'b100101) return 4'b0001;
    if (f == 6'b100110) return 4'b0011;
    if (f == 6'b100111) return 4'b1100;
    if (f == 6'b101010) return 4'b0111;
    return 4'b0010;
  endfunction

  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [32:0] sa, sb;
    sa = {a[31], a};
    sb = {b[31], b};
    if (op == 4'b0000) return a & b;
    if (op == 4'b0001) return a | b;
    if (op == 4'b0011) return a ^ b;
    if (op == 4'b1100) return ~(a | b);
    if (op == 4'b0010) return a + b;
    if (op == 4'b0110) return a - b;
    if (op == 4'b0111) return (sa < sb) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  task automatic apply(input string tag, input logic rst, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] se, input logic [9:0] pc,
                       input logic [1:0] aop, input logic src);
    exp_t e, g;
    logic [31:0] bb;
    @(posedge clock);
    reset = rst; inData1 = a; inData2 = b; signExtend = se;
    inPC = pc; aluOp = aop; aluSrc = src;
    bb     = src ? se : b;
    e.tag  = tag;
    e.op   = model_op(aop, se[5:0]);
    if (rst) begin
      e.res = 32'd0; e.zf = 1'b0; e.pc = 10'd0;
    end else begin
      e.res = model_alu(e.op, a, bb);
      e.zf  = (e.res == 32'd0);
      e.pc  = 10'((11'(pc) + 11'(se[9:0])) % 11'd1024);
    end
    exp_q.push_back(e);
    @(negedge clock);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      g = exp_q.pop_front();
      check({g.tag, "_res"}, aluResult, g.res);
      check({g.tag, "_zero"}, {31'd0, zero}, {31'd0, g.zf});
      check({g.tag, "_pc"}, {22'd0, outPC}, {22'd0, g.pc});
      check({g.tag, "_op"}, {28'd0, operation}, {28'd0, g.op});
    end
  endtask

  logic [5:0] functs [8];

  initial begin
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
               6'b100110, 6'b100111, 6'b101010, 6'b000011};
    reset = 1'b1; inData1 = 32'd0; inData2 = 32'd0; signExtend = 32'd0;
    inPC = 10'd0; aluOp = 2'b00; aluSrc = 1'b0;
    #1;
    check("init_zero", {31'd0, zero}, 32'd0);
    @(negedge clock); #1;
    check("rst_res", aluResult, 32'd0);
    check("rst_pc", {22'd0, outPC}, 32'd0);

    apply("add",      0, 32'd5, 32'd7, 32'h20, 10'd0, 2'b10, 0);
    apply("sub_eq",   0, 32'h1234, 32'h1234, 32'd0, 10'd1, 2'b01, 0);
    apply("slt_neg",  0, 32'hFFFFFFFF, 32'd1, 32'h2A, 10'd2, 2'b10, 0);
    apply("slt_swap", 0, 32'd1, 32'hFFFFFFFF, 32'h2A, 10'd3, 2'b10, 0);
    apply("addi",     0, 32'd100, 32'hDEADBEEF, 32'hFFFFFFFC, 10'd4, 2'b00, 1);
    apply("pc_wrap",  0, 32'd0, 32'd0, 32'd4, 10'h3FE, 2'b00, 1);
    apply("and",      0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h24, 10'd9, 2'b10, 0);
    apply("or",       0, 32'hF000_0000, 32'h0000_000F, 32'h25, 10'd9, 2'b10, 0);
    apply("xor_self", 0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h26, 10'd9, 2'b10, 0);
    apply("nor",      0, 32'h0000_FFFF, 32'h00FF_0000, 32'h27, 10'd9, 2'b10, 0);
    apply("bad_fn",   0, 32'd3, 32'd4, 32'h3F, 10'd9, 2'b10, 0);
    apply("aop11",    0, 32'hFFFF_FFFF, 32'd1, 32'h22, 10'd9, 2'b11, 0);
    apply("add_ovf",  0, 32'h7FFF_FFFF, 32'd1, 32'h20, 10'd9, 2'b10, 0);
    apply("rst_mid",  1, 32'd5, 32'd7, 32'h20, 10'd55, 2'b10, 0);
    apply("resume",   0, 32'd5, 32'd7, 32'h20, 10'd55, 2'b10, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] se;
      se = $urandom;
      se[5:0] = functs[$urandom_range(0, 7)];
      apply($sformatf("rnd%0d", i), ($urandom_range(0, 9) == 0), $urandom, $urandom,
            se, 10'($urandom), 2'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
